alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The module SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter XLEN, default 64, SHALL set the datapath width; the legal values are 32 and 64.
REQ-003 Parameter RADDR, default 5, SHALL set the destination-register tag width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: a request is present.
REQ-007 Port in_ready, output, 1 bit: the unit can accept a request.
REQ-008 Port funct3, input, 3 bits: RV M-extension op. 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU, 4=DIV, 5=DIVU, 6=REM, 7=REMU.
REQ-009 Port is_word, input, 1 bit: selects the *W variant (32-bit op); it SHALL be ignored when XLEN=32.
REQ-010 Port op_a, input, XLEN bits: rs1 value.
REQ-011 Port op_b, input, XLEN bits: rs2 value.
REQ-012 Port rd, input, RADDR bits: destination tag.
REQ-013 Port flush, input, 1 bit: kill the in-flight operation.
REQ-014 Port out_valid, output, 1 bit: a result is present.
REQ-015 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-016 Port out_data, output, XLEN bits: the result value.
REQ-017 Port out_rd, output, RADDR bits: the destination tag of the result.
REQ-018 Port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on an edge where in_valid=1, in_ready=1 and flush=0.
REQ-022 On accept, the unit SHALL latch funct3, is_word, rd and the prepared operands.
REQ-023 Operand width W SHALL be 32 when is_word=1, otherwise XLEN.
REQ-024 Word operands SHALL be bits [31:0], sign-extended for signed ops and zero-extended for unsigned ops.
REQ-025 Multiply SHALL run as an iterative shift-add on unsigned magnitudes, one bit per cycle, for W cycles, producing a 2W-bit product.
REQ-026 The multiply result sign SHALL be fixed at the end by two's-complement negation when the operand signs differ (signed operands only).
REQ-027 MUL SHALL return product[W-1:0]; MULH, MULHSU and MULHU SHALL return product[2W-1:W].
REQ-028 Divide SHALL run as an iterative restoring division on magnitudes, one quotient bit per cycle, for W cycles.
REQ-029 For signed divide, the quotient sign SHALL be sign(a) XOR sign(b) and the remainder sign SHALL be sign(a).
REQ-030 Divide by zero SHALL bypass CALC, go directly to DONE, and return quotient = all ones and remainder = dividend.
REQ-031 Signed overflow (most-negative / -1) SHALL bypass CALC, go directly to DONE, and return quotient = dividend and remainder = 0.
REQ-032 Latency for a normal op SHALL be W+1 cycles: accept at edge 0, out_valid=1 after edge W+1. Bypass ops SHALL have out_valid=1 after edge 1.
REQ-033 An iteration counter of clog2(XLEN)+1 bits SHALL load W on accept, decrement once per CALC cycle, and move the FSM CALC->DONE at 1->0.
REQ-034 Word results SHALL be sign-extended from bit 31 to XLEN, for every funct3 including DIVUW and REMUW.
REQ-035 In DONE: out_valid=1, and out_data and out_rd SHALL be held stable until out_ready=1.
REQ-036 DONE with out_ready=1 SHALL go to IDLE on the next edge; a new request SHALL NOT be accepted on that edge.
REQ-037 flush=1 in any state SHALL force IDLE on the next edge, drop the result, and clear out_valid.
REQ-038 When flush and in_valid are both 1 on the same edge, flush SHALL win and the request SHALL NOT be accepted.
REQ-039 rd=0 SHALL still produce a result; suppressing the write is the consumer's job.

Reset
REQ-040 While reset=0: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, out_rd=0, counter=0, and all datapath registers SHALL be cleared.
REQ-041 Reset asserted mid-CALC SHALL abort the operation immediately, with no output.
REQ-042 After reset is released, the first accept SHALL be possible on the first rising edge.

Verification
REQ-043 XLEN=64, MUL a=-3, b=7: out_data=0xFFFFFFFFFFFFFFEB; out_valid rises 65 cycles after accept.
REQ-044 MULHU a=b=0xFFFFFFFFFFFFFFFF -> out_data=0xFFFFFFFFFFFFFFFE; MULH of the same operands -> 0.
REQ-045 DIV a=7, b=0 -> out_data=all ones after 1 cycle; REM a=0x8000000000000000, b=-1 -> out_data=0 after 1 cycle.
REQ-046 DIVW a=0x00000000FFFFFFF9 (-7 as a word), b=2 -> out_data=0xFFFFFFFFFFFFFFFD; REMW of the same operands -> 0xFFFFFFFFFFFFFFFF; latency 33 cycles.
REQ-047 Hold out_ready=0 for 10 cycles in DONE -> out_data stable and in_ready=0 throughout; then flush=1 together with in_valid=1 -> IDLE, out_valid=0, no accept.
REQ-048 Assert reset=0 at CALC cycle 20 of a DIVU -> all outputs at reset values; re-issue the DIVU -> correct result with the full latency.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension multiply/divide unit.
// One operation in flight. A multiply is a radix-2 shift-add and a divide is a
// restoring division, both on unsigned magnitudes with a sign fix at the end.
// Divide-by-zero and signed overflow skip the iteration and finish immediately.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (ready only in IDLE)
//   funct3, is_word      op select (0..7 = MUL..REMU), *W variant when XLEN=64
//   op_a, op_b, rd       operands and destination tag
//   flush                kill whatever is in flight, back to IDLE
//   out_valid/out_ready  result handshake; out_data/out_rd held until taken
//   busy                 FSM not in IDLE
module alu_muldiv #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic             is_word,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [RADDR-1:0] rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [RADDR-1:0] out_rd,
  output logic             busy
);

  localparam int unsigned CW       = $clog2(XLEN) + 1;
  localparam int unsigned P2       = 2 * XLEN;
  localparam int unsigned WSH      = XLEN - 32;
  localparam bit          HAS_WORD = (XLEN == 64);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic              r_word;
  logic              r_neg;
  logic              r_rneg;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opd;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_data;
  logic [RADDR-1:0]  r_out_rd;

  // Operand preparation
  logic              w_word;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic [XLEN-1:0]   w_ax;
  logic [XLEN-1:0]   w_bx;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic [XLEN-1:0]   w_min;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_bypass;
  logic [XLEN-1:0]   w_byp_res;
  logic [XLEN-1:0]   w_byp_out;

  // Iteration and result formatting
  logic [XLEN:0]     w_msum;
  logic [XLEN:0]     w_rsh;
  logic [XLEN:0]     w_rsub;
  logic [XLEN-1:0]   w_hi_nx;
  logic [XLEN-1:0]   w_lo_nx;
  logic [P2-1:0]     w_p;
  logic [P2-1:0]     w_ps;
  logic [XLEN-1:0]   w_mhi;
  logic [XLEN-1:0]   w_mres;
  logic [XLEN-1:0]   w_qs;
  logic [XLEN-1:0]   w_rs;
  logic [XLEN-1:0]   w_res;
  logic [XLEN-1:0]   w_fin;

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;

  // Sign-extend/zero-extend operands, take magnitudes, detect bypass cases
  always_comb begin
    w_word  = is_word & HAS_WORD;
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (funct3)
      3'd0, 3'd1, 3'd4, 3'd6: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      3'd2:                   begin w_sgn_a = 1'b1; w_sgn_b = 1'b0; end
      default:                begin w_sgn_a = 1'b0; w_sgn_b = 1'b0; end
    endcase

    w_ax = op_a;
    w_bx = op_b;
    if (w_word) begin
      w_ax = w_sgn_a ? XLEN'($signed(op_a[31:0])) : XLEN'(op_a[31:0]);
      w_bx = w_sgn_b ? XLEN'($signed(op_b[31:0])) : XLEN'(op_b[31:0]);
    end
    w_a_neg = w_sgn_a & w_ax[XLEN-1];
    w_b_neg = w_sgn_b & w_bx[XLEN-1];
    w_ma    = w_a_neg ? (~w_ax + XLEN'(1)) : w_ax;
    w_mb    = w_b_neg ? (~w_bx + XLEN'(1)) : w_bx;

    w_min    = w_word ? ({XLEN{1'b1}} << 31) : (XLEN'(1) << (XLEN - 1));
    w_b_zero = (w_bx == '0);
    w_ovf    = w_sgn_a & funct3[2] & (w_ax == w_min) & (w_bx == '1);
    w_bypass = funct3[2] & (w_b_zero | w_ovf);

    // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (funct3[1]) w_byp_res = w_b_zero ? w_ax : '0;
    else           w_byp_res = w_b_zero ? '1   : w_ax;
    w_byp_out = w_word ? XLEN'($signed(w_byp_res[31:0])) : w_byp_res;
  end

  // One iteration step; the final result is formed from the last step's values
  always_comb begin
    w_msum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opd : '0)};
    w_rsh  = {r_hi, r_lo[XLEN-1]};
    w_rsub = w_rsh - {1'b0, r_opd};
    if (r_f3[2]) begin
      // restoring step: keep the difference when it did not borrow
      w_hi_nx = w_rsub[XLEN] ? w_rsh[XLEN-1:0] : w_rsub[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], ~w_rsub[XLEN]};
    end else begin
      w_hi_nx = w_msum[XLEN:1];
      w_lo_nx = {w_msum[0], r_lo[XLEN-1:1]};
    end

    // A word multiply leaves its 64-bit product 32 places up in the register pair
    w_p    = {w_hi_nx, w_lo_nx};
    if (r_word) w_p = w_p >> WSH;
    w_ps   = r_neg ? (~w_p + P2'(1)) : w_p;
    w_mhi  = r_word ? XLEN'(w_ps[63:32]) : w_ps[P2-1:XLEN];
    w_mres = (r_f3[1:0] == 2'd0) ? w_ps[XLEN-1:0] : w_mhi;

    w_qs  = r_neg  ? (~w_lo_nx + XLEN'(1)) : w_lo_nx;
    w_rs  = r_rneg ? (~w_hi_nx + XLEN'(1)) : w_hi_nx;
    w_res = r_f3[2] ? (r_f3[1] ? w_rs : w_qs) : w_mres;
    w_fin = r_word ? XLEN'($signed(w_res[31:0])) : w_res;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_word      <= 1'b0;
      r_neg       <= 1'b0;
      r_rneg      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opd       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_f3       <= funct3;
            r_word     <= w_word;
            r_out_rd   <= rd;
            r_neg      <= w_a_neg ^ w_b_neg;
            r_rneg     <= w_a_neg;
            r_hi       <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_bypass) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= w_byp_out;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= w_word ? CW'(32) : CW'(XLEN);
              if (funct3[2]) begin
                // dividend is shifted out MSB-first, so park a word at the top
                r_opd <= w_mb;
                r_lo  <= w_word ? (w_ma << WSH) : w_ma;
              end else begin
                r_opd <= w_ma;
                r_lo  <= w_mb;
              end
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_fin;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=64): directed vector table,
// handshake/flush/reset sequences, and random ops against an arithmetic model.
module tb_alu_muldiv;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RADDR = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic             is_word;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [RADDR-1:0] rd;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [RADDR-1:0] out_rd;
  logic             busy;

  int n_pass  = 0;
  int n_total = 0;

  alu_muldiv #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .is_word(is_word), .op_a(op_a), .op_b(op_b), .rd(rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Operand as a signed 130-bit value: the W-bit field, sign- or zero-extended
  function automatic logic signed [129:0] ext(input logic [63:0] x, input bit w, input bit sgn);
    logic signed [129:0] v;
    if (w) begin
      if (sgn) v = 130'($signed(x[31:0]));
      else     v = 130'(x[31:0]);
    end else begin
      if (sgn) v = 130'($signed(x));
      else     v = 130'(x);
    end
    return v;
  endfunction

  // Reference: plain wide arithmetic, then truncate to W and sign-extend words
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input bit w,
                                            input logic [63:0] a, input logic [63:0] b,
                                            output int lat);
    logic signed [129:0] va, vb, p, q, r, mn;
    logic [63:0] res;
    bit sa, sb;
    int wd;
    wd = w ? 32 : 64;
    sa = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    sb = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    va = ext(a, w, sa);
    vb = ext(b, w, sb);
    lat = wd + 1;
    if (!f3[2]) begin
      p = va * vb;
      if (f3 == 3'd0) res = p[63:0];
      else if (w)     res = 64'(p[63:32]);
      else            res = p[127:64];
    end else begin
      if (vb == 0) begin
        q = -1;
        r = va;
        lat = 1;
      end else begin
        q = va / vb;
        r = va % vb;
        mn = 1;
        mn = -(mn <<< (wd - 1));
        if (sa && va == mn && vb == -1) lat = 1;
      end
      res = f3[1] ? r[63:0] : q[63:0];
    end
    if (w) res = 64'($signed(res[31:0]));
    return res;
  endfunction

  task automatic drive(input logic [2:0] f3, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] t);
    funct3 = f3; is_word = w; op_a = a; op_b = b; rd = t; in_valid = 1'b1;
  endtask

  // Called at the first negedge after the accepting edge; counts cycles to out_valid
  task automatic wait_result(output logic [63:0] d, output logic [4:0] dr, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_timeout", 64'(out_valid), 64'd1);
    d  = out_data;
    dr = out_rd;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t,
                        output logic [63:0] d, output logic [4:0] dr, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    drive(f3, w, a, b, t);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(d, dr, lat);
  endtask

  typedef struct {
    logic [2:0]  f3;
    bit          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t        tbl[14];
  logic [63:0] d;
  logic [4:0]  dr;
  int          lat;
  int          elat;
  logic [63:0] ed;
  logic [63:0] ra, rb;
  logic [2:0]  rf;
  bit          rw;
  int          guard;

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 64'hFFFFFFFFFFFFFFFD, 64'd7,                64'hFFFFFFFFFFFFFFEB, 65};
    tbl[1]  = '{3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65};
    tbl[2]  = '{3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0,               65};
    tbl[3]  = '{3'd4, 1'b0, 64'd7,                64'd0,                64'hFFFFFFFFFFFFFFFF, 1};
    tbl[4]  = '{3'd6, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0,               1};
    tbl[5]  = '{3'd4, 1'b1, 64'h00000000FFFFFFF9, 64'd2,                64'hFFFFFFFFFFFFFFFD, 33};
    tbl[6]  = '{3'd6, 1'b1, 64'h00000000FFFFFFF9, 64'd2,                64'hFFFFFFFFFFFFFFFF, 33};
    tbl[7]  = '{3'd4, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1};
    tbl[8]  = '{3'd7, 1'b0, 64'd100,              64'd0,                64'd100,             1};
    tbl[9]  = '{3'd5, 1'b1, 64'h0000000080000000, 64'd1,                64'hFFFFFFFF80000000, 33};
    tbl[10] = '{3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2,                64'hFFFFFFFFFFFFFFFF, 65};
    tbl[11] = '{3'd0, 1'b1, 64'h000000007FFFFFFF, 64'd2,                64'hFFFFFFFFFFFFFFFE, 33};
    tbl[12] = '{3'd6, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2,                64'hFFFFFFFFFFFFFFFF, 65};
    tbl[13] = '{3'd5, 1'b0, 64'd100,              64'd7,                64'd14,              65};

    reset = 1'b0; in_valid = 1'b0; funct3 = '0; is_word = 1'b0;
    op_a = '0; op_b = '0; rd = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    reset = 1'b1;

    // Directed vectors; tag 0 on the first one must still produce a result
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].b, 5'(i), d, dr, lat);
      chk($sformatf("vec%0d_data", i), d, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("vec%0d_rd", i), 64'(dr), 64'(i));
    end

    // Hold the result with out_ready low, then flush together with a new request
    @(negedge clk);
    drive(3'd5, 1'b0, 64'd1000, 64'd3, 5'd9);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_data", out_data, 64'd333);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    chk("hold_rd", 64'(out_rd), 64'd9);
    flush = 1'b1;
    drive(3'd0, 1'b0, 64'd5, 64'd6, 5'd3);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_no_accept", 64'(busy), 64'd0);

    // Flush in the middle of an iteration, then the unit works normally
    drive(3'd0, 1'b0, 64'd11, 64'd13, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("calc_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("midflush_busy", 64'(busy), 64'd0);
    chk("midflush_out_valid", 64'(out_valid), 64'd0);
    run_op(3'd0, 1'b0, 64'd11, 64'd13, 5'd4, d, dr, lat);
    chk("after_flush_data", d, 64'd143);

    // Reset during CALC of a DIVU, then reissue straight out of reset
    @(negedge clk);
    drive(3'd5, 1'b0, 64'd1000, 64'd7, 5'd12);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    chk("midrst_no_output", 64'(out_valid), 64'd0);
    drive(3'd5, 1'b0, 64'd1000, 64'd7, 5'd12);
    #2 reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(d, dr, lat);
    chk("reissue_data", d, 64'd142);
    chk("reissue_lat", 64'(lat), 64'd65);
    chk("reissue_rd", 64'(dr), 64'd12);

    // Random ops against the arithmetic model, biased toward divide corners
    for (int i = 0; i < 200; i++) begin
      rf = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin
          rb = '1;
          ra = rw ? 64'h0000000080000000 : 64'h8000000000000000;
        end
        2: begin
          ra = 64'($urandom_range(0, 300)) - 64'd150;
          rb = 64'($urandom_range(0, 20)) - 64'd10;
        end
        default: ;
      endcase
      ed = ref_model(rf, rw, ra, rb, elat);
      run_op(rf, rw, ra, rb, 5'(i), d, dr, lat);
      chk($sformatf("rnd%0d_f%0d_w%0d_data", i, rf, rw), d, ed);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
